fp_normalize: RTL and testbench

FP_NORMALIZE -- requirements
Module: fp_normalize

---
 rtl/fp_norm_pkg.sv | 17 +
 rtl/fp_norm_step.sv | 58 +++++
 rtl/fp_normalize.sv | 93 +++++++++
 tb/tb_fp_normalize.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the floating-point result normalizer.
package fp_norm_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Default-width reference constants (single precision)
  localparam logic [EXP_W_DEF-1:0]           EXP_INF   = '1;
  localparam logic [EXP_W_DEF+MAN_W_DEF:0]   ZERO_WORD = '0;

endpackage

// File: rtl/fp_norm_step.sv
// One normalization decision: either finishes with a packed word, or
// produces the next (exp, man) after a single left shift.
module fp_norm_step
  import fp_norm_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                   i_sign,
  input  logic [EXP_W-1:0]       i_exp,
  input  logic [MAN_W+1:0]       i_man,
  output logic [EXP_W-1:0]       o_exp,
  output logic [MAN_W+1:0]       o_man,
  output logic                   o_done,
  output logic [EXP_W+MAN_W:0]   o_word
);

  localparam logic [EXP_W-1:0] L_EXP_ONES = '1;
  localparam logic [MAN_W-1:0] L_FRAC_0   = '0;

  // Exponent math one bit wider so neither direction can wrap
  logic [EXP_W:0] w_exp_inc;
  logic [EXP_W:0] w_exp_dec;
  logic           w_exp_small;
  logic           w_inc_ovf;

  assign w_exp_inc   = {1'b0, i_exp} + (EXP_W+1)'(1);
  assign w_exp_dec   = {1'b0, i_exp} - (EXP_W+1)'(1);
  assign w_exp_small = ({1'b0, i_exp} <= (EXP_W+1)'(1));
  assign w_inc_ovf   = (w_exp_inc >= {1'b0, L_EXP_ONES});

  // Priority-ordered rule set; first matching rule decides the cycle
  always_comb begin
    o_exp  = i_exp;
    o_man  = i_man;
    o_done = 1'b1;
    o_word = '0;
    if (i_exp == L_EXP_ONES) begin
      o_word = {i_sign, L_EXP_ONES, L_FRAC_0};
    end else if (i_man == '0) begin
      o_word = '0;
    end else if (i_man[MAN_W+1]) begin
      // carry out: shift right once, bump exponent, saturate to infinity
      if (w_inc_ovf) o_word = {i_sign, L_EXP_ONES, L_FRAC_0};
      else           o_word = {i_sign, w_exp_inc[EXP_W-1:0], i_man[MAN_W:1]};
    end else if (i_man[MAN_W]) begin
      o_word = {i_sign, i_exp, i_man[MAN_W-1:0]};
    end else if (w_exp_small) begin
      // would go subnormal: flush to +0
      o_word = '0;
    end else begin
      o_done = 1'b0;
      o_man  = i_man << 1;
      o_exp  = w_exp_dec[EXP_W-1:0];
    end
  end

endmodule

// File: rtl/fp_normalize.sv
// Iterative normalizer for raw adder results: one left shift per cycle,
// packed IEEE word held in DONE until the consumer takes it.
module fp_normalize
  import fp_norm_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [MAN_W+1:0]       in_man,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic                   busy
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_sign;
  logic [EXP_W-1:0]       r_exp;
  logic [MAN_W+1:0]       r_man;
  logic [EXP_W+MAN_W:0]   r_data;

  logic [EXP_W-1:0]       w_exp;
  logic [MAN_W+1:0]       w_man;
  logic                   w_done;
  logic [EXP_W+MAN_W:0]   w_word;

  fp_norm_step #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_step (
    .i_sign (r_sign),
    .i_exp  (r_exp),
    .i_man  (r_man),
    .o_exp  (w_exp),
    .o_man  (w_man),
    .o_done (w_done),
    .o_word (w_word)
  );

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state: accept in IDLE, iterate in NORM, hand off in DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_NORM;
      S_NORM:  if (w_done)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Working registers and result word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_man  <= '0;
      r_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_sign <= in_sign;
          r_exp  <= in_exp;
          r_man  <= in_man;
        end
        S_NORM: begin
          if (w_done) begin
            r_data <= w_word;
          end else begin
            r_exp <= w_exp;
            r_man <= w_man;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_NORM) || (r_state == S_DONE);
  assign out_data  = r_data;

endmodule

// File: tb/tb_fp_normalize.sv
// Vector table + scoreboard bench for fp_normalize (single precision).
module tb_fp_normalize;
  import fp_norm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [24:0] in_man = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] man;
    logic [31:0] data;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t  sb[$];
  vec_t  vecs[10];

  fp_normalize #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_man    (in_man),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Drive one vector at a negedge, accept on the following posedge
  task automatic accept(input vec_t v);
    @(negedge clk);
    in_sign  = v.sign;
    in_exp   = v.exp;
    in_man   = v.man;
    in_valid = 1'b1;
    chk("in_ready_before_accept", 64'(in_ready), 64'(1));
    @(posedge clk);
    sb.push_back('{data: v.data, lat: v.lat});
    #1 in_valid = 1'b0;
  endtask

  // Called 1 time unit after the accept edge; counts edges until out_valid
  task automatic collect(input string name);
    int   lat;
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!out_valid) begin
      chk({name, "_timeout"}, 64'(0), 64'(1));
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk({name, "_unexpected"}, 64'(1), 64'(0));
    end else begin
      e = sb.pop_front();
      chk({name, "_data"}, 64'(out_data), 64'(e.data));
      chk({name, "_lat"},  64'(lat),      64'(e.lat));
      chk({name, "_busy"}, 64'(busy),     64'(1));
    end
  endtask

  // Consumer takes the word at the next edge; block must be IDLE afterwards
  task automatic release_out(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_idle_ready"}, 64'(in_ready),  64'(1));
    chk({name, "_idle_valid"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    logic [31:0] hold;

    vecs[0] = '{0, 8'h80, 25'h1800000, 32'h40C00000, 1};   // carry, 6.0
    vecs[1] = '{0, 8'h82, 25'h0200000, 32'h40000000, 3};   // two left shifts
    vecs[2] = '{1, 8'h90, 25'h0000000, 32'h00000000, 1};   // zero mantissa -> +0
    vecs[3] = '{0, 8'h02, 25'h0000001, 32'h00000000, 2};   // flush
    vecs[4] = '{0, 8'hFE, 25'h1000000, 32'h7F800000, 1};   // overflow -> inf
    vecs[5] = '{1, 8'hFF, 25'h0123456, 32'hFF800000, 1};   // exp all-ones
    vecs[6] = '{0, 8'hFF, 25'h0000000, 32'h7F800000, 1};   // exp rule precedes zero rule
    vecs[7] = '{1, 8'h7F, 25'h0800000, 32'hBF800000, 1};   // already normal, -1.0
    vecs[8] = '{0, 8'h90, 25'h0000001, 32'h3C800000, 24};  // max shift count
    vecs[9] = '{0, 8'h10, 25'h1FFFFFF, 32'h08FFFFFF, 1};   // carry keeps fraction

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data",  64'(out_data),  64'(ZERO_WORD));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b1;
      accept(vecs[i]);
      collect($sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_idle", i), 64'(in_ready), 64'(1));
    end

    // Back-pressure: result held, inputs ignored while DONE
    @(negedge clk);
    out_ready = 1'b0;
    accept(vecs[0]);
    collect("bp");
    hold = out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = i[0] ? 1'b0 : 1'b1;
      in_sign  = 1'b1;
      in_exp   = 8'($urandom_range(1, 254));
      in_man   = 25'($urandom);
      @(posedge clk);
      #1;
      chk("bp_data_stable", 64'(out_data),  64'(hold));
      chk("bp_in_ready",    64'(in_ready),  64'(0));
      chk("bp_out_valid",   64'(out_valid), 64'(1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out("bp");
    accept(vecs[1]);
    collect("bp_next");
    @(posedge clk);
    #1;

    // Reset mid-NORM aborts the operation
    accept(vecs[1]);
    @(posedge clk);
    #1 chk("abort_busy_before", 64'(busy), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_out_data",  64'(out_data),  64'(ZERO_WORD));
    chk("abort_in_ready",  64'(in_ready),  64'(1));
    chk("abort_busy",      64'(busy),      64'(0));
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 chk("abort_no_stale", 64'(out_valid), 64'(0));
    end
    accept(vecs[7]);
    collect("after_abort");
    @(posedge clk);
    #1;

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
